// File: rtl/nbcac_23di_pkg.sv
// Shared constants for the 23-bit NB-CAC link: widths, weight set, FSM states.
// Weights are indexed to match codeword wire numbering [33:1].
package nbcac_23di_pkg;
  localparam int N_DATA = 23;
  localparam int N_WIRE = 33;

  localparam logic [31:0] S [1:33] = '{
    32'd1,
    32'd4356618, 32'd2692538, 32'd1664080, 32'd1028458,
    32'd635622,  32'd392836,  32'd242786,  32'd150050,
    32'd92736,   32'd57314,   32'd35422,   32'd21892,
    32'd13530,   32'd8362,    32'd5168,    32'd3194,
    32'd1974,    32'd1220,    32'd754,     32'd466,
    32'd288,     32'd178,     32'd110,     32'd68,
    32'd42,      32'd26,      32'd16,      32'd10,
    32'd6,       32'd4,       32'd2,       32'd2
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;
endpackage

// File: rtl/nbcac_23di_weight_rom.sv
// Combinational weight lookup; indices outside 1..33 return zero.
// Shared between the iterative encoder and any iterative decoder.
module nbcac_23di_weight_rom
  import nbcac_23di_pkg::*;
(
  input  logic [5:0]        idx,
  output logic [N_DATA-1:0] w
);
  always_comb begin
    w = '0;
    if (idx >= 6'd1 && idx <= 6'd33)
      w = S[idx][N_DATA-1:0];
  end
endmodule

// File: rtl/nbcac_23di_encoder_iter.sv
// Iterative NB-CAC encoder: greedy subtraction over the weight set,
// one weight per clock, valid/ready on both sides.
module nbcac_23di_encoder_iter #(
  parameter int N_DATA = 23,
  parameter int N_WIRE = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_DATA-1:0] v_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_WIRE:1]   d_out,
  output logic              err
);
  import nbcac_23di_pkg::*;

  state_e            state_q, state_d;
  logic [N_DATA-1:0] r_q, r_d;
  logic [5:0]        idx_q, idx_d;
  logic [N_WIRE:1]   d_q, d_d;
  logic              err_q, err_d;
  logic [N_DATA-1:0] w;
  logic              accept;

  nbcac_23di_weight_rom u_rom (
    .idx (idx_q),
    .w   (w)
  );

  assign in_ready  = !rst && (state_q == IDLE ||
                     (state_q == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign d_out     = d_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    idx_d   = idx_q;
    d_d     = d_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (r_q >= w) begin
          d_d[idx_q] = 1'b1;
          r_d        = r_q - w;
        end
        if (idx_q == 6'(N_WIRE)) begin
          state_d = DONE;
          idx_d   = 6'd2;
          err_d   = (r_d != '0);
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Bit 0 goes straight to the weight-1 wire; the rest is greedy.
    if (accept) begin
      state_d = RUN;
      d_d     = {{(N_WIRE-1){1'b0}}, v_in[0]};
      r_d     = {v_in[N_DATA-1:1], 1'b0};
      idx_d   = 6'd2;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      idx_q   <= 6'd2;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      err_q   <= err_d;
    end
  end
endmodule
